mm_console_stream_arbiter: RTL and testbench
============================================

Name: mm_console_stream_arbiter

Overview:
- Packet-aware round-robin arbiter that shares one 8-bit Avalon-ST console byte stream between NUM_SRC requesters. Typical requesters are the debug console, the boot log and the DAQ status reporter.
- The output feeds the console timing adapter / JTAG master sink.
- Once a source wins, it keeps the stream until its end-of-packet beat is accepted, so packets are never interleaved.
- A watchdog releases the stream if the granted source stalls mid-packet.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- SRC_W, 2, width of the source index; must equal clog2(NUM_SRC).
- TIMEOUT, 1024, idle cycles tolerated mid-packet before forced release (≥2).
- TO_W, 11, width of the watchdog counter; must hold TIMEOUT.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous reset, active-high.
- in_valid  in  NUM_SRC  per-source valid.
- in_data  in  NUM_SRC*8  per-source byte; source i occupies bits [8i+7:8i].
- in_sop  in  NUM_SRC  per-source startofpacket.
- in_eop  in  NUM_SRC  per-source endofpacket.
- in_ready  out  NUM_SRC  per-source ready; at most one bit set.
- out_valid  out  1  merged valid.
- out_data  out  8  merged byte.
- out_sop  out  1  merged startofpacket.
- out_eop  out  1  merged endofpacket.
- out_channel  out  SRC_W  index of the source driving the output.
- out_ready  in  1  downstream ready.
- timeout_err  out  1  one-cycle pulse on watchdog release.
- busy  out  1  high while in LOCKED.

Behaviour:
- Reset values:
  - state = IDLE; last_grant = NUM_SRC-1, so source 0 has first priority.
  - grant = 0; watchdog count = 0; timeout_err = 0.
  - out_valid = 0, in_ready = 0, busy = 0.
  - out_data, out_sop and out_eop are don't-care while out_valid = 0; the bench checks them only when out_valid = 1.
- State machine, two states:
  - IDLE: in_ready = 0, out_valid = 0. Request vector = in_valid. If any request is set, choose the first set bit scanning from last_grant+1 upward, modulo NUM_SRC. Register it into grant and last_grant, then go to LOCKED. No requests: stay in IDLE.
  - LOCKED: zero-latency combinational pass-through from source g = grant:
    - out_valid = in_valid[g], out_data/out_sop/out_eop = source g fields, out_channel = g.
    - in_ready[g] = out_ready; all other in_ready bits are 0.
    - An accepted beat is out_valid & out_ready.
    - An accepted beat with out_eop = 1 returns the FSM to IDLE on the next edge.
- Arbitration cost: one bubble cycle (IDLE) between packets. Minimum packet-to-packet gap is 1 cycle.
- Fairness: with all sources requesting continuously, grants rotate 0,1,2,3,0,...
- Single-beat packet (sop & eop in one accepted beat): held for exactly that beat, then IDLE.
- Backpressure (out_ready = 0): lock and data are held. The watchdog does not count while in_valid[g] = 1, because a stalled sink is not a source fault.
- Watchdog, LOCKED only:
  - Counter clears on every accepted beat and whenever in_valid[g] = 1.
  - Counter increments while in_valid[g] = 0.
  - When the count reaches TIMEOUT-1 with in_valid[g] still 0: timeout_err pulses for one cycle, the FSM goes to IDLE and last_grant keeps g, so the faulty source loses priority.
  - No eop is synthesised; downstream sees a truncated packet.
- Source validity: no sop check. A source that starts without sop is forwarded as-is, and the sink owns framing errors.
- Simultaneous events: an eop accept in the same cycle the watchdog would fire gives a normal release with no timeout_err. Eop accept wins.
- Sources not granted see in_ready = 0 and must hold their data (Avalon-ST ready latency 0).
- Reset asserted mid-packet: immediate asynchronous return to the reset state. The in-flight packet is dropped, with no eop emitted.
- busy = (state == LOCKED).

Decomposition:
- Shared package mm_console_pkg holds:
  - the state enum (ST_IDLE, ST_LOCKED);
  - the byte width constant CONSOLE_DW = 8.
- One natural sub-module: mm_console_rr_pick. It is combinational round-robin selection, taking the request vector and last_grant and returning a found flag and the winning index. It is reusable by the command-side demux.

Test Plan:
- Single source: NUM_SRC = 4; source 2 sends 3 bytes 0x41, 0x42, 0x43 (sop on 1st, eop on 3rd) with out_ready = 1 → out_channel = 2; bytes appear on cycles 1–3 after valid; busy drops after the 3rd; in_ready[0,1,3] stay 0.
- Fairness: sources 0–3 each continuously send 2-byte packets → grant order 0,1,2,3,0,1; exactly one IDLE cycle between packets; no byte interleaving.
- Backpressure: source 1 in packet 0x10..0x13; out_ready low for 2000 cycles after the 2nd byte → data held stable at 0x11; no timeout_err; packet completes after out_ready rises.
- Watchdog: TIMEOUT = 16; source 3 sends sop byte 0xAA and then drops valid → timeout_err pulses on the 16th idle cycle; next grant goes to source 0 if it is requesting.
- Mid-packet reset: assert reset during the 2nd byte of a 4-byte packet from source 1 → out_valid and in_ready go 0 asynchronously; after release, source 0 is granted first.
- Edge: a single-beat packet (sop = eop = 1, 0x55) from source 0, while source 1 also requests → one beat from 0, one IDLE cycle, then source 1 granted.

Source files
------------

// File: rtl/mm_console_pkg.sv
// Shared definitions for the console stream arbiter and its helpers.
//   state_e    : arbiter FSM states (ST_IDLE, ST_LOCKED)
//   CONSOLE_DW : console byte width
package mm_console_pkg;

    localparam int CONSOLE_DW = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/mm_console_stream_arbiter_if.sv
// Avalon-ST bundle between NUM_SRC console sources, the arbiter and the sink.
//   in_valid/in_data/in_sop/in_eop : per-source beat, source i in byte lane i
//   in_ready                       : per-source ready, at most one bit set
//   out_valid/out_data/out_sop/out_eop/out_channel : merged stream
//   out_ready                      : downstream ready
// master = sources + sink side, slave = arbiter side.
interface mm_console_stream_arbiter_if
    import mm_console_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2
) ();

    logic [NUM_SRC-1:0]            in_valid;
    logic [NUM_SRC*CONSOLE_DW-1:0] in_data;
    logic [NUM_SRC-1:0]            in_sop;
    logic [NUM_SRC-1:0]            in_eop;
    logic [NUM_SRC-1:0]            in_ready;
    logic                          out_valid;
    logic [CONSOLE_DW-1:0]         out_data;
    logic                          out_sop;
    logic                          out_eop;
    logic [SRC_W-1:0]              out_channel;
    logic                          out_ready;

    modport master (
        output in_valid, in_data, in_sop, in_eop, out_ready,
        input  in_ready, out_valid, out_data, out_sop, out_eop, out_channel
    );

    modport slave (
        input  in_valid, in_data, in_sop, in_eop, out_ready,
        output in_ready, out_valid, out_data, out_sop, out_eop, out_channel
    );

endinterface

// File: rtl/mm_console_rr_pick.sv
// Combinational round-robin pick.
//   req_i        : request vector
//   last_grant_i : previous winner; scanning starts at last_grant_i+1
//   found_o      : any request set
//   idx_o        : winning index (0 when found_o = 0)
module mm_console_rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [SRC_W-1:0]   last_grant_i,
    output logic               found_o,
    output logic [SRC_W-1:0]   idx_o
);

    localparam logic [SRC_W:0] NUM_SRC_X = (SRC_W+1)'(NUM_SRC);

    logic [SRC_W:0] cand;

    // The loop ends on k = NUM_SRC, which revisits last_grant_i itself last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = {1'b0, last_grant_i} + (SRC_W+1)'(k);
            if (cand >= NUM_SRC_X) begin
                cand = cand - NUM_SRC_X;
            end
            if (!found_o && req_i[cand[SRC_W-1:0]]) begin
                found_o = 1'b1;
                idx_o   = cand[SRC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mm_console_stream_arbiter.sv
// Packet-aware round-robin arbiter for the shared console byte stream.
//   clk, reset  : clock, asynchronous active-high reset
//   st          : stream bundle (slave side), see mm_console_stream_arbiter_if
//   timeout_err : one-cycle pulse after the watchdog releases a stalled source
//   busy        : high while a source owns the stream
//
// state     | meaning
// ST_IDLE   | no owner; pick next requester round-robin (one bubble cycle)
// ST_LOCKED | grant_q owns the stream until its eop is accepted or watchdog
module mm_console_stream_arbiter
    import mm_console_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic clk,
    input  logic reset,
    mm_console_stream_arbiter_if.slave st,
    output logic timeout_err,
    output logic busy
);

    state_e           state_q, state_d;
    logic [SRC_W-1:0] grant_q, grant_d;
    logic [SRC_W-1:0] last_grant_q, last_grant_d;
    logic [TO_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic             timeout_err_q, timeout_err_d;

    logic                  pick_found;
    logic [SRC_W-1:0]      pick_idx;
    logic                  locked;
    logic                  g_valid, g_sop, g_eop;
    logic [CONSOLE_DW-1:0] g_data;
    logic [NUM_SRC-1:0]    in_ready_c;
    logic                  accept;

    mm_console_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_rr_pick (
        .req_i        (st.in_valid),
        .last_grant_i (last_grant_q),
        .found_o      (pick_found),
        .idx_o        (pick_idx)
    );

    assign locked = (state_q == ST_LOCKED);

    // Mux of the granted source's fields; zero-latency pass-through.
    always_comb begin
        g_valid    = 1'b0;
        g_sop      = 1'b0;
        g_eop      = 1'b0;
        g_data     = '0;
        in_ready_c = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == SRC_W'(i)) begin
                g_valid       = st.in_valid[i];
                g_sop         = st.in_sop[i];
                g_eop         = st.in_eop[i];
                g_data        = st.in_data[i*CONSOLE_DW +: CONSOLE_DW];
                in_ready_c[i] = locked & st.out_ready;
            end
        end
    end

    assign st.out_valid   = locked & g_valid;
    assign st.out_data    = g_data;
    assign st.out_sop     = g_sop;
    assign st.out_eop     = g_eop;
    assign st.out_channel = grant_q;
    assign st.in_ready    = in_ready_c;
    assign accept         = st.out_valid & st.out_ready;
    assign timeout_err    = timeout_err_q;
    assign busy           = locked;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        wd_cnt_d      = wd_cnt_q;
        timeout_err_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                wd_cnt_d = '0;
                if (pick_found) begin
                    grant_d      = pick_idx;
                    last_grant_d = pick_idx;
                    state_d      = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                // Only a missing source beat counts; sink backpressure with
                // valid held is not a source fault. last_grant_q already
                // holds the owner, so a timed-out source drops to lowest
                // priority.
                if (accept && g_eop) begin
                    wd_cnt_d = '0;
                    state_d  = ST_IDLE;
                end else if (g_valid) begin
                    wd_cnt_d = '0;
                end else if (wd_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    wd_cnt_d      = '0;
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            last_grant_q  <= SRC_W'(NUM_SRC - 1);
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_mm_console_stream_arbiter.sv
// Bench for mm_console_stream_arbiter: queue-driven sources, a cycle-level
// reference model of ownership/round-robin/watchdog, and directed scenarios.
module tb_mm_console_stream_arbiter;

    localparam int N   = 4;
    localparam int SW  = 2;
    localparam int TO  = 16;
    localparam int TOW = 5;

    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        int         gap_after;
    } beat_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic timeout_err;
    logic busy;

    mm_console_stream_arbiter_if #(.NUM_SRC(N), .SRC_W(SW)) st ();

    mm_console_stream_arbiter #(
        .NUM_SRC (N),
        .SRC_W   (SW),
        .TIMEOUT (TO),
        .TO_W    (TOW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .st          (st),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    beat_t      src_q[N][$];
    logic [7:0] exp_src[N][$];
    int         gap_cnt[N];
    bit         rand_ready;
    logic       ready_val;
    logic [N-1:0] cur_v;
    logic       cur_rdy;

    // reference model
    bit m_locked;
    int m_owner;
    int m_last;
    int m_idle;
    bit m_terr;
    int cyc = 0;

    int         acc_chan[$];
    logic [7:0] acc_data[$];
    int         acc_cyc[$];
    int         terr_cyc[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_beat(input int s, input logic [7:0] d, input logic sop, input logic eop, input int gap);
        beat_t b;
        b.d = d; b.sop = sop; b.eop = eop; b.gap_after = gap;
        src_q[s].push_back(b);
        exp_src[s].push_back(d);
    endtask

    task automatic drive_inputs();
        for (int s = 0; s < N; s++) begin
            cur_v[s] = (gap_cnt[s] == 0) && (src_q[s].size() > 0);
            if (cur_v[s]) begin
                st.in_data[s*8 +: 8] = src_q[s][0].d;
                st.in_sop[s]         = src_q[s][0].sop;
                st.in_eop[s]         = src_q[s][0].eop;
            end else begin
                st.in_data[s*8 +: 8] = 8'($urandom);
                st.in_sop[s]         = 1'($urandom);
                st.in_eop[s]         = 1'($urandom);
            end
        end
        st.in_valid  = cur_v;
        cur_rdy      = rand_ready ? ($urandom_range(3) != 0) : ready_val;
        st.out_ready = cur_rdy;
    endtask

    task automatic compare_and_log();
        logic [N-1:0] exp_rdy;
        logic         exp_valid;
        exp_rdy = '0;
        if (m_locked) exp_rdy[m_owner] = cur_rdy;
        exp_valid = m_locked && cur_v[m_owner];
        check_eq("busy", busy, m_locked);
        check_eq("timeout_err", timeout_err, m_terr);
        check_eq("in_ready", st.in_ready, exp_rdy);
        check_eq("out_valid", st.out_valid, exp_valid);
        if (exp_valid) begin
            check_eq("out_data", st.out_data, src_q[m_owner][0].d);
            check_eq("out_sop", st.out_sop, src_q[m_owner][0].sop);
            check_eq("out_eop", st.out_eop, src_q[m_owner][0].eop);
            check_eq("out_channel", st.out_channel, m_owner);
        end
        if (st.out_valid === 1'b1 && cur_rdy) begin
            acc_chan.push_back(int'(st.out_channel));
            acc_data.push_back(st.out_data);
            acc_cyc.push_back(cyc);
        end
        if (timeout_err === 1'b1) terr_cyc.push_back(cyc);
    endtask

    task automatic advance_model();
        beat_t b;
        bit    popped;
        bit    found;
        int    ps;
        int    s;
        popped = 1'b0;
        ps     = 0;
        m_terr = 1'b0;
        if (!m_locked) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                s = (m_last + k) % N;
                if (!found && cur_v[s]) begin
                    found    = 1'b1;
                    m_locked = 1'b1;
                    m_owner  = s;
                    m_last   = s;
                    m_idle   = 0;
                end
            end
        end else if (cur_v[m_owner]) begin
            m_idle = 0;
            if (cur_rdy) begin
                b      = src_q[m_owner].pop_front();
                popped = 1'b1;
                ps     = m_owner;
                if (b.eop) m_locked = 1'b0;
            end
        end else begin
            m_idle++;
            if (m_idle >= TO) begin
                m_terr   = 1'b1;
                m_locked = 1'b0;
                m_idle   = 0;
            end
        end
        for (int j = 0; j < N; j++) if (gap_cnt[j] > 0) gap_cnt[j]--;
        if (popped) gap_cnt[ps] = b.gap_after;
    endtask

    task automatic step();
        drive_inputs();
        #1;
        compare_and_log();
        @(posedge clk);
        #1;
        cyc++;
        advance_model();
    endtask

    task automatic clear_all();
        for (int s = 0; s < N; s++) begin
            src_q[s].delete();
            exp_src[s].delete();
            gap_cnt[s] = 0;
        end
        acc_chan.delete();
        acc_data.delete();
        acc_cyc.delete();
        terr_cyc.delete();
        m_locked = 1'b0;
        m_owner  = 0;
        m_last   = N - 1;
        m_idle   = 0;
        m_terr   = 1'b0;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        st.in_valid  = '0;
        st.in_sop    = '0;
        st.in_eop    = '0;
        st.in_data   = '0;
        st.out_ready = 1'b1;
        rand_ready   = 1'b0;
        ready_val    = 1'b1;
        clear_all();
        #1;
        check_eq("rst_out_valid", st.out_valid, 1'b0);
        check_eq("rst_in_ready", st.in_ready, '0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_timeout_err", timeout_err, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic bit pending();
        bit p;
        p = m_locked || m_terr;
        for (int s = 0; s < N; s++) if (src_q[s].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (pending() && n < max_cyc) begin
            step();
            n++;
        end
        check_eq("drain_bound", (n < max_cyc), 1'b1);
        repeat (2) step();
    endtask

    initial begin
        int c0;
        int n;
        int idx[N];

        // single source, 3-byte packet from source 2
        do_reset();
        push_beat(2, 8'h41, 1'b1, 1'b0, 0);
        push_beat(2, 8'h42, 1'b0, 1'b0, 0);
        push_beat(2, 8'h43, 1'b0, 1'b1, 0);
        c0 = cyc;
        drain(50);
        check_eq("single_cnt", acc_data.size(), 3);
        if (acc_data.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check_eq("single_data", acc_data[i], 8'h41 + 8'(i));
                check_eq("single_chan", acc_chan[i], 2);
                check_eq("single_cyc", acc_cyc[i] - c0, i + 1);
            end
        end
        check_eq("single_busy_end", busy, 1'b0);

        // fairness: every source streams 2-byte packets back to back
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int s = 0; s < N; s++) begin
                push_beat(s, 8'((s << 4) | (2*r)),     1'b1, 1'b0, 0);
                push_beat(s, 8'((s << 4) | (2*r + 1)), 1'b0, 1'b1, 0);
            end
        drain(200);
        check_eq("fair_cnt", acc_chan.size(), 24);
        if (acc_chan.size() == 24) begin
            for (int i = 0; i < 12; i++) begin
                check_eq("fair_chan", acc_chan[i], (i / 2) % N);
                if (i > 0) check_eq("fair_gap", acc_cyc[i] - acc_cyc[i-1], (i % 2 == 1) ? 1 : 2);
            end
        end

        // backpressure with valid held far longer than the watchdog limit
        do_reset();
        push_beat(1, 8'h10, 1'b1, 1'b0, 0);
        push_beat(1, 8'h11, 1'b0, 1'b0, 0);
        push_beat(1, 8'h12, 1'b0, 1'b0, 0);
        push_beat(1, 8'h13, 1'b0, 1'b1, 0);
        n = 0;
        while (acc_data.size() < 1 && n < 20) begin step(); n++; end
        check_eq("bp_first_bound", (n < 20), 1'b1);
        ready_val = 1'b0;
        repeat (2000) step();
        check_eq("bp_held_data", st.out_data, 8'h11);
        check_eq("bp_held_valid", st.out_valid, 1'b1);
        check_eq("bp_no_timeout", terr_cyc.size(), 0);
        ready_val = 1'b1;
        drain(50);
        check_eq("bp_cnt", acc_data.size(), 4);
        if (acc_data.size() == 4)
            for (int i = 0; i < 4; i++) check_eq("bp_data", acc_data[i], 8'h10 + 8'(i));

        // watchdog: source 3 stalls after its sop beat; source 0 joins late
        do_reset();
        push_beat(3, 8'hAA, 1'b1, 1'b0, 100);
        push_beat(3, 8'hAB, 1'b0, 1'b1, 0);
        push_beat(0, 8'h01, 1'b1, 1'b1, 0);
        gap_cnt[0] = 3;
        drain(400);
        check_eq("wd_pulses", terr_cyc.size(), 1);
        check_eq("wd_cnt", acc_chan.size(), 3);
        if (terr_cyc.size() == 1 && acc_chan.size() == 3) begin
            check_eq("wd_first_chan", acc_chan[0], 3);
            check_eq("wd_pulse_cyc", terr_cyc[0] - acc_cyc[0], TO + 1);
            check_eq("wd_next_chan", acc_chan[1], 0);
            check_eq("wd_next_cyc", acc_cyc[1] - acc_cyc[0], TO + 2);
        end

        // single-beat packet from 0 while 1 is also requesting
        do_reset();
        push_beat(0, 8'h55, 1'b1, 1'b1, 0);
        push_beat(1, 8'h60, 1'b1, 1'b0, 0);
        push_beat(1, 8'h61, 1'b0, 1'b1, 0);
        c0 = cyc;
        drain(50);
        check_eq("edge_cnt", acc_chan.size(), 3);
        if (acc_chan.size() == 3) begin
            check_eq("edge_chan0", acc_chan[0], 0);
            check_eq("edge_data0", acc_data[0], 8'h55);
            check_eq("edge_cyc0", acc_cyc[0] - c0, 1);
            check_eq("edge_chan1", acc_chan[1], 1);
            check_eq("edge_cyc1", acc_cyc[1] - c0, 3);
        end

        // asynchronous reset during the 2nd beat of a packet from source 1
        do_reset();
        push_beat(1, 8'h20, 1'b1, 1'b0, 0);
        push_beat(1, 8'h21, 1'b0, 1'b0, 0);
        push_beat(1, 8'h22, 1'b0, 1'b0, 0);
        push_beat(1, 8'h23, 1'b0, 1'b1, 0);
        step();
        step();
        drive_inputs();
        #1;
        check_eq("mid_pre_valid", st.out_valid, 1'b1);
        check_eq("mid_pre_data", st.out_data, 8'h21);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid_async_valid", st.out_valid, 1'b0);
        check_eq("mid_async_ready", st.in_ready, '0);
        check_eq("mid_async_busy", busy, 1'b0);
        clear_all();
        push_beat(1, 8'h31, 1'b1, 1'b1, 0);
        push_beat(0, 8'h30, 1'b1, 1'b1, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drain(50);
        check_eq("mid_after_cnt", acc_chan.size(), 2);
        if (acc_chan.size() == 2) begin
            check_eq("mid_after_chan0", acc_chan[0], 0);
            check_eq("mid_after_chan1", acc_chan[1], 1);
        end

        // randomized traffic with random backpressure and short source gaps
        do_reset();
        rand_ready = 1'b1;
        for (int s = 0; s < N; s++)
            for (int p = 0; p < 6; p++) begin
                int len;
                len = $urandom_range(4, 1);
                for (int b = 0; b < len; b++)
                    push_beat(s, 8'($urandom), (b == 0), (b == len - 1), $urandom_range(3, 0));
            end
        drain(5000);
        for (int s = 0; s < N; s++) idx[s] = 0;
        for (int i = 0; i < acc_chan.size(); i++) begin
            int ch;
            ch = acc_chan[i];
            if (ch >= 0 && ch < N && idx[ch] < exp_src[ch].size()) begin
                check_eq("rand_order", acc_data[i], exp_src[ch][idx[ch]]);
                idx[ch]++;
            end else begin
                check_eq("rand_extra_beat", ch, 32'hFFFF_FFFF);
            end
        end
        for (int s = 0; s < N; s++) check_eq("rand_src_done", idx[s], exp_src[s].size());
        check_eq("rand_no_timeout", terr_cyc.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
